// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Main control FSM for the multicycle MIPS datapath. It steps one instruction
// through fetch, decode, execute, memory and write-back over a shared ALU and
// a single memory port. FETCH, MEMRD and MEMWR wait for MemReady from memory.
//
// Build option:
//   MULTICYCLE_IMM_OPS_EN  when defined, adds the IMMEX/IMMWB states and the
//                          addi/andi/ori/slti opcodes. When undefined, those
//                          opcodes take the illegal path.
// -----------------------------------------------------------------------------
module multicycle_control (
   input  logic       Clk,
   input  logic       RstN,
   input  logic [5:0] Op,
   input  logic       MemReady,
   output logic       PcWrite,
   output logic       PcWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IrWrite,
   output logic       MemToReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       AluSrcA,
   output logic [1:0] AluSrcB,
   output logic [1:0] PcSource,
   output logic [2:0] Aop,
   output logic       Illegal,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      MEMADR = 4'd3,
      MEMRD  = 4'd4,
      MEMWB  = 4'd5,
      MEMWR  = 4'd6,
      EXEC   = 4'd7,
      RWB    = 4'd8,
      BRANCH = 4'd9,
      JUMP   = 4'd10,
      IMMEX  = 4'd11,
      IMMWB  = 4'd12
   } state_t;

   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpSlti  = 6'b001010;

   localparam logic [2:0] AopAdd   = 3'b000;
   localparam logic [2:0] AopRtype = 3'b001;
   localparam logic [2:0] AopSub   = 3'b010;
   localparam logic [2:0] AopAnd   = 3'b011;
   localparam logic [2:0] AopOr    = 3'b100;
   localparam logic [2:0] AopSlt   = 3'b101;

   state_t state_q;
   state_t state_d;

   // Set on the first clock edge after reset release; IDLE waits for it so the
   // first FETCH lands one full cycle after the edge that sees reset released.
   logic   started_q;

   logic   isLw;
   logic   isSw;
   logic   isRtype;
   logic   isBeq;
   logic   isJ;
   logic   isImm;
   logic   isKnown;

   // Classify the opcode once so next-state and Illegal share the same decode
   always_comb begin
      isLw    = (Op == OpLw);
      isSw    = (Op == OpSw);
      isRtype = (Op == OpRtype);
      isBeq   = (Op == OpBeq);
      isJ     = (Op == OpJ);
`ifdef MULTICYCLE_IMM_OPS_EN
      isImm   = (Op == OpAddi) || (Op == OpAndi) || (Op == OpOri) || (Op == OpSlti);
`else
      isImm   = 1'b0;
`endif
      isKnown = isLw || isSw || isRtype || isBeq || isJ || isImm;
   end

   // State register with asynchronous reset so every output drops at once
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         state_q   <= IDLE;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         started_q <= 1'b1;
      end
   end

   // Next-state selection; memory states hold until MemReady
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (started_q) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (MemReady) begin
               state_d = DECODE;
            end
         end
         DECODE: begin
            if (isLw || isSw) begin
               state_d = MEMADR;
            end else if (isRtype) begin
               state_d = EXEC;
            end else if (isBeq) begin
               state_d = BRANCH;
            end else if (isJ) begin
               state_d = JUMP;
`ifdef MULTICYCLE_IMM_OPS_EN
            end else if (isImm) begin
               state_d = IMMEX;
`endif
            end else begin
               state_d = FETCH;
            end
         end
         MEMADR: begin
            state_d = isLw ? MEMRD : MEMWR;
         end
         MEMRD: begin
            if (MemReady) begin
               state_d = MEMWB;
            end
         end
         MEMWB:  state_d = FETCH;
         MEMWR: begin
            if (MemReady) begin
               state_d = FETCH;
            end
         end
         EXEC:   state_d = RWB;
         RWB:    state_d = FETCH;
         BRANCH: state_d = FETCH;
         JUMP:   state_d = FETCH;
`ifdef MULTICYCLE_IMM_OPS_EN
         IMMEX:  state_d = IMMWB;
         IMMWB:  state_d = FETCH;
`endif
         default: state_d = IDLE;
      endcase
   end

   // Moore output decode; only the FETCH register loads look at MemReady
   always_comb begin
      PcWrite     = 1'b0;
      PcWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IrWrite     = 1'b0;
      MemToReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      AluSrcA     = 1'b0;
      AluSrcB     = 2'b00;
      PcSource    = 2'b00;
      Aop         = AopAdd;
      Illegal     = 1'b0;
      case (state_q)
         FETCH: begin
            MemRead = 1'b1;
            AluSrcB = 2'b01;
            IrWrite = MemReady;
            PcWrite = MemReady;
         end
         DECODE: begin
            AluSrcB = 2'b11;
            Illegal = !isKnown;
         end
         MEMADR: begin
            AluSrcA = 1'b1;
            AluSrcB = 2'b10;
         end
         MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         MEMWB: begin
            RegWrite = 1'b1;
            MemToReg = 1'b1;
         end
         MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         EXEC: begin
            AluSrcA = 1'b1;
            Aop     = AopRtype;
         end
         RWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         BRANCH: begin
            AluSrcA     = 1'b1;
            Aop         = AopSub;
            PcWriteCond = 1'b1;
            PcSource    = 2'b01;
         end
         JUMP: begin
            PcWrite  = 1'b1;
            PcSource = 2'b10;
         end
`ifdef MULTICYCLE_IMM_OPS_EN
         IMMEX: begin
            AluSrcA = 1'b1;
            AluSrcB = 2'b10;
            case (Op)
               OpAndi:  Aop = AopAnd;
               OpOri:   Aop = AopOr;
               OpSlti:  Aop = AopSlt;
               default: Aop = AopAdd;
            endcase
         end
         IMMWB: begin
            RegWrite = 1'b1;
         end
`endif
         default: begin
         end
      endcase
   end

   assign State = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Self-checking bench for multicycle_control: a table of test-plan cycles, a
// jump sequence, an asynchronous reset during a stalled store, and randomized
// instructions checked against an instruction-path reference model.
// Honours MULTICYCLE_IMM_OPS_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

   logic       Clk;
   logic       RstN;
   logic [5:0] Op;
   logic       MemReady;
   logic       PcWrite;
   logic       PcWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IrWrite;
   logic       MemToReg;
   logic       RegDst;
   logic       RegWrite;
   logic       AluSrcA;
   logic [1:0] AluSrcB;
   logic [1:0] PcSource;
   logic [2:0] Aop;
   logic       Illegal;
   logic [3:0] State;

`ifdef MULTICYCLE_IMM_OPS_EN
   localparam bit ImmEn = 1'b1;
`else
   localparam bit ImmEn = 1'b0;
`endif

   multicycle_control dut (
      .Clk        (Clk),
      .RstN       (RstN),
      .Op         (Op),
      .MemReady   (MemReady),
      .PcWrite    (PcWrite),
      .PcWriteCond(PcWriteCond),
      .IorD       (IorD),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .IrWrite    (IrWrite),
      .MemToReg   (MemToReg),
      .RegDst     (RegDst),
      .RegWrite   (RegWrite),
      .AluSrcA    (AluSrcA),
      .AluSrcB    (AluSrcB),
      .PcSource   (PcSource),
      .Aop        (Aop),
      .Illegal    (Illegal),
      .State      (State)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   logic [21:0] dutVec;
   assign dutVec = {PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IrWrite,
                    MemToReg, RegDst, RegWrite, AluSrcA, AluSrcB, PcSource,
                    Aop, Illegal, State};

   int numChecks = 0;
   int numPassed = 0;

   typedef struct {
      logic [5:0] op;
      logic       rdy;
      logic [3:0] st;
      logic [2:0] aop;
      logic       regWrite;
      logic       regDst;
      logic       memRead;
      logic       memWrite;
      logic       iorD;
      logic       pcWriteCond;
      logic       illegal;
   } vec_t;

   vec_t vecs[$];
   int   expPath[$];

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, BAD = 6'b111111;
   localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100;
   localparam logic [5:0] ORI = 6'b001101, SLTI = 6'b001010;

   task automatic addVec(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                         input logic [2:0] aop, input logic rw, input logic rd,
                         input logic mr, input logic mw, input logic iod,
                         input logic pwc, input logic ill);
      vec_t v;
      v.op = op; v.rdy = rdy; v.st = st; v.aop = aop;
      v.regWrite = rw; v.regDst = rd; v.memRead = mr; v.memWrite = mw;
      v.iorD = iod; v.pcWriteCond = pwc; v.illegal = ill;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input logic [5:0] op, input logic rdy);
      Op       = op;
      MemReady = rdy;
   endtask

   task automatic checkOutput(input string name, input logic [21:0] act, input logic [21:0] exp);
      numChecks++;
      if (act === exp) begin
         numPassed++;
      end else begin
         $display("[TB] FAIL %s: got %06h, expected %06h (State got %0d exp %0d)",
                  name, act, exp, act[3:0], exp[3:0]);
      end
   endtask

   task automatic nextEdge();
      @(posedge Clk);
      #1;
   endtask

   function automatic bit knownOp(input logic [5:0] op);
      if (op == LW || op == SW || op == RT || op == BEQ || op == JMP) return 1'b1;
      if (ImmEn && (op == ADDI || op == ANDI || op == ORI || op == SLTI)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit isImmOp(input logic [5:0] op);
      return ImmEn && (op == ADDI || op == ANDI || op == ORI || op == SLTI);
   endfunction

   // Expected output bundle for a given step of an instruction
   function automatic logic [21:0] expOuts(input int st, input logic [5:0] op, input logic rdy);
      logic pcW, pcWC, iod, mr, mw, irW, m2r, rd, rw, srcA, ill;
      logic [1:0] srcB, pcSrc;
      logic [2:0] aop;
      {pcW, pcWC, iod, mr, mw, irW, m2r, rd, rw, srcA, ill} = '0;
      srcB = 2'b00; pcSrc = 2'b00; aop = 3'b000;
      case (st)
         1:  begin mr = 1; srcB = 2'b01; irW = rdy; pcW = rdy; end
         2:  begin srcB = 2'b11; ill = !knownOp(op); end
         3:  begin srcA = 1; srcB = 2'b10; end
         4:  begin mr = 1; iod = 1; end
         5:  begin rw = 1; m2r = 1; end
         6:  begin mw = 1; iod = 1; end
         7:  begin srcA = 1; aop = 3'b001; end
         8:  begin rw = 1; rd = 1; end
         9:  begin srcA = 1; aop = 3'b010; pcWC = 1; pcSrc = 2'b01; end
         10: begin pcW = 1; pcSrc = 2'b10; end
         11: begin
                srcA = 1; srcB = 2'b10;
                aop = (op == ANDI) ? 3'b011 : (op == ORI) ? 3'b100 :
                      (op == SLTI) ? 3'b101 : 3'b000;
             end
         12: begin rw = 1; end
         default: begin end
      endcase
      return {pcW, pcWC, iod, mr, mw, irW, m2r, rd, rw, srcA, srcB, pcSrc,
              aop, ill, 4'(st)};
   endfunction

   // Sequence of states an instruction visits, starting at FETCH
   task automatic buildPath(input logic [5:0] op);
      expPath = {1, 2};
      if (op == LW)           expPath = {1, 2, 3, 4, 5};
      else if (op == SW)      expPath = {1, 2, 3, 6};
      else if (op == RT)      expPath = {1, 2, 7, 8};
      else if (op == BEQ)     expPath = {1, 2, 9};
      else if (op == JMP)     expPath = {1, 2, 10};
      else if (isImmOp(op))   expPath = {1, 2, 11, 12};
   endtask

   logic [5:0] rOp;
   logic       rRdy;
   int         rSt;
   int         rStalls;
   bit         rDone;
   logic [21:0] packAct;
   logic [21:0] packExp;

   initial begin
      RstN = 1'b0;
      applyStimulus(6'b101010, 1'b1);

      // Test-plan cycles: {op, MemReady, State, Aop, RegWrite, RegDst, MemRead, MemWrite, IorD, PcWriteCond, Illegal}
      addVec(RT,  1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
      addVec(RT,  1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
      addVec(RT,  1, 1, 3'b000, 0, 0, 1, 0, 0, 0, 0);
      addVec(RT,  1, 2, 3'b000, 0, 0, 0, 0, 0, 0, 0);
      addVec(RT,  1, 7, 3'b001, 0, 0, 0, 0, 0, 0, 0);
      addVec(RT,  1, 8, 3'b000, 1, 1, 0, 0, 0, 0, 0);
      addVec(LW,  1, 1, 3'b000, 0, 0, 1, 0, 0, 0, 0);
      addVec(LW,  1, 2, 3'b000, 0, 0, 0, 0, 0, 0, 0);
      addVec(LW,  1, 3, 3'b000, 0, 0, 0, 0, 0, 0, 0);
      addVec(LW,  0, 4, 3'b000, 0, 0, 1, 0, 1, 0, 0);
      addVec(LW,  0, 4, 3'b000, 0, 0, 1, 0, 1, 0, 0);
      addVec(LW,  1, 4, 3'b000, 0, 0, 1, 0, 1, 0, 0);
      addVec(LW,  1, 5, 3'b000, 1, 0, 0, 0, 0, 0, 0);
      addVec(SW,  1, 1, 3'b000, 0, 0, 1, 0, 0, 0, 0);
      addVec(SW,  1, 2, 3'b000, 0, 0, 0, 0, 0, 0, 0);
      addVec(SW,  1, 3, 3'b000, 0, 0, 0, 0, 0, 0, 0);
      addVec(SW,  1, 6, 3'b000, 0, 0, 0, 1, 1, 0, 0);
      addVec(BEQ, 0, 1, 3'b000, 0, 0, 1, 0, 0, 0, 0);
      addVec(BEQ, 1, 1, 3'b000, 0, 0, 1, 0, 0, 0, 0);
      addVec(BEQ, 1, 2, 3'b000, 0, 0, 0, 0, 0, 0, 0);
      addVec(BEQ, 1, 9, 3'b010, 0, 0, 0, 0, 0, 1, 0);
      addVec(BAD, 1, 1, 3'b000, 0, 0, 1, 0, 0, 0, 0);
      addVec(BAD, 1, 2, 3'b000, 0, 0, 0, 0, 0, 0, 1);
      addVec(ORI, 1, 1, 3'b000, 0, 0, 1, 0, 0, 0, 0);
`ifdef MULTICYCLE_IMM_OPS_EN
      addVec(ORI, 1, 2,  3'b000, 0, 0, 0, 0, 0, 0, 0);
      addVec(ORI, 1, 11, 3'b100, 0, 0, 0, 0, 0, 0, 0);
      addVec(ORI, 1, 12, 3'b000, 1, 0, 0, 0, 0, 0, 0);
`else
      addVec(ORI, 1, 2,  3'b000, 0, 0, 0, 0, 0, 0, 1);
`endif

      // Reset state is all zero while RstN is low
      repeat (2) @(posedge Clk);
      #1;
      checkOutput("reset_hold", dutVec, 22'h0);
      RstN = 1'b1;

      $display("[TB] table vectors");
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].rdy);
         @(negedge Clk);
         packAct = {9'h0, State, Aop, RegWrite, RegDst, MemRead, MemWrite, IorD,
                    PcWriteCond, Illegal};
         packExp = {9'h0, vecs[i].st, vecs[i].aop, vecs[i].regWrite, vecs[i].regDst,
                    vecs[i].memRead, vecs[i].memWrite, vecs[i].iorD,
                    vecs[i].pcWriteCond, vecs[i].illegal};
         checkOutput($sformatf("vec%0d", i), packAct, packExp);
         nextEdge();
      end

      $display("[TB] jump sequence");
      foreach (expPath[k]) expPath.delete(k);
      buildPath(JMP);
      foreach (expPath[k]) begin
         applyStimulus(JMP, 1'b1);
         @(negedge Clk);
         checkOutput($sformatf("jump_s%0d", expPath[k]), dutVec, expOuts(expPath[k], JMP, 1'b1));
         nextEdge();
      end

      $display("[TB] async reset during stalled store");
      for (int s = 1; s <= 3; s++) begin
         applyStimulus(SW, 1'b1);
         @(negedge Clk);
         checkOutput($sformatf("swrst_s%0d", s), dutVec, expOuts(s, SW, 1'b1));
         nextEdge();
      end
      applyStimulus(SW, 1'b0);
      @(negedge Clk);
      checkOutput("swrst_memwr", dutVec, expOuts(6, SW, 1'b0));
      #2;
      RstN = 1'b0;
      #1;
      checkOutput("swrst_async_zero", dutVec, 22'h0);
      nextEdge();
      RstN = 1'b1;
      for (int s = 0; s < 2; s++) begin
         applyStimulus(SW, 1'b1);
         @(negedge Clk);
         checkOutput($sformatf("swrst_idle%0d", s), dutVec, 22'h0);
         nextEdge();
      end

      $display("[TB] randomized instructions");
      for (int n = 0; n < 200; n++) begin
         case ($urandom_range(0, 9))
            0: rOp = LW;
            1: rOp = SW;
            2: rOp = RT;
            3: rOp = BEQ;
            4: rOp = JMP;
            5: rOp = ADDI;
            6: rOp = ANDI;
            7: rOp = ORI;
            8: rOp = SLTI;
            default: rOp = 6'($urandom);
         endcase
         buildPath(rOp);
         foreach (expPath[k]) begin
            rSt     = expPath[k];
            rStalls = 0;
            rDone   = 1'b0;
            while (!rDone) begin
               rRdy = 1'($urandom_range(0, 1));
               if (rStalls >= 4) rRdy = 1'b1;
               if (rSt == 2 || rSt == 3 || rSt == 11) applyStimulus(rOp, rRdy);
               else applyStimulus(6'($urandom), rRdy);
               @(negedge Clk);
               checkOutput($sformatf("rand%0d_op%02h_s%0d", n, rOp, rSt), dutVec,
                           expOuts(rSt, rOp, rRdy));
               nextEdge();
               if ((rSt == 1 || rSt == 4 || rSt == 6) && !rRdy) rStalls++;
               else rDone = 1'b1;
            end
         end
      end

      $display("%0d/%0d checks passed", numPassed, numChecks);
      $finish;
   end

endmodule
